// File: rtl/y86_pkg.sv
// Shared Y86 register-ID constants and scoreboard FSM state type.
package y86_pkg;
  localparam logic [3:0] RRSP  = 4'd4;
  localparam logic [3:0] RNONE = 4'hF;
  localparam int         NREG  = 15;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} sb_state_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/squash/drain signal bundle between pipeline control and the scoreboard.
interface reg_scoreboard_if;
  import y86_pkg::*;

  logic            d_valid;
  logic [3:0]      d_srcA, d_srcB, d_dstE, d_dstM;
  logic            issue, stall_d;
  logic            w_valid;
  logic [3:0]      w_dstE, w_dstM;
  logic            s_valid;
  logic [3:0]      s_dstE, s_dstM;
  logic            drain_req, drain_done;
  logic [NREG-1:0] busy_mask;
  logic            err;

  modport master (
    output d_valid, d_srcA, d_srcB, d_dstE, d_dstM,
    output w_valid, w_dstE, w_dstM, s_valid, s_dstE, s_dstM, drain_req,
    input  issue, stall_d, drain_done, busy_mask, err
  );

  modport slave (
    input  d_valid, d_srcA, d_srcB, d_dstE, d_dstM,
    input  w_valid, w_dstE, w_dstM, s_valid, s_dstE, s_dstM, drain_req,
    output issue, stall_d, drain_done, busy_mask, err
  );
endinterface

// File: rtl/sb_counter.sv
// Per-register pending-write counter: one net up/down update per cycle, saturating at 0 and 3.
module sb_counter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] inc,
  input  logic [2:0] dec,
  output logic [1:0] cnt,
  output logic       busy,
  output logic       clamp
);
  logic signed [3:0] net;
  logic [1:0]        cnt_nxt;

  always_comb begin
    net     = $signed({2'b00, cnt}) + $signed({2'b00, inc}) - $signed({1'b0, dec});
    cnt_nxt = net[1:0];
    clamp   = 1'b0;
    if (net < 0) begin
      cnt_nxt = 2'd0;
      clamp   = 1'b1;
    end else if (net > 4'sd3) begin
      cnt_nxt = 2'd3;
      clamp   = 1'b1;
    end
  end

  // busy is registered from the next count so it never sees current-cycle inputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= 2'd0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= (cnt_nxt != 2'd0);
    end
  end
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per register, stalls decode on hazards,
// and sequences a drain (RUN -> DRAIN -> DONE) for quiescing the pipeline.
//   state | meaning
//   RUN   | normal issue
//   DRAIN | issue blocked, waiting for all pending writes to retire
//   DONE  | quiesced, waiting for drain_req to drop
module reg_scoreboard import y86_pkg::*; #(
  parameter int unsigned MAX_PEND = 3,
  parameter logic [3:0]  RNONE    = y86_pkg::RNONE
) (
  input logic             clock,
  input logic             reset_n,
  reg_scoreboard_if.slave sb
);
  logic [1:0]      inc_req [NREG];
  logic [2:0]      dec     [NREG];
  logic [1:0]      cnt     [NREG];
  logic [NREG-1:0] busy, clamp;
  logic            src_hit, over, stall, issue, drain_done, err;
  sb_state_t       state, state_nxt;

  function automatic logic hit(logic [3:0] id, int r);
    return (id != RNONE) && (id == 4'(r));
  endfunction

  always_comb begin
    src_hit = 1'b0;
    over    = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      inc_req[r] = {1'b0, hit(sb.d_dstE, r)} + {1'b0, hit(sb.d_dstM, r)};
      dec[r]     = {2'b00, sb.w_valid & hit(sb.w_dstE, r)} + {2'b00, sb.w_valid & hit(sb.w_dstM, r)}
                 + {2'b00, sb.s_valid & hit(sb.s_dstE, r)} + {2'b00, sb.s_valid & hit(sb.s_dstM, r)};
      if ((cnt[r] != 2'd0) && (hit(sb.d_srcA, r) || hit(sb.d_srcB, r)))
        src_hit = 1'b1;
      if (({1'b0, cnt[r]} + {1'b0, inc_req[r]}) > 3'(MAX_PEND))
        over = 1'b1;
    end
  end

  // while in reset the stall follows d_valid alone, which also forces issue low
  assign stall = sb.d_valid && (!reset_n || src_hit || over || (state != RUN));
  assign issue = sb.d_valid && !stall;

  for (genvar g = 0; g < NREG; g++) begin : g_cnt
    sb_counter u_cnt (
      .clock  (clock),
      .reset_n(reset_n),
      .inc    (issue ? inc_req[g] : 2'd0),
      .dec    (dec[g]),
      .cnt    (cnt[g]),
      .busy   (busy[g]),
      .clamp  (clamp[g])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= err | (|clamp);
    end
  end

  always_comb begin
    state_nxt  = state;
    drain_done = 1'b0;
    case (state)
      RUN:     if (sb.drain_req) state_nxt = DRAIN;
      DRAIN:   if ((busy == '0) && !issue) begin
                 state_nxt  = DONE;
                 drain_done = 1'b1;
               end
      DONE:    if (!sb.drain_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign sb.issue      = issue;
  assign sb.stall_d    = stall;
  assign sb.drain_done = drain_done;
  assign sb.busy_mask  = busy;
  assign sb.err        = err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: vector table for hazards/counting, hand sequences for drain and reset.
module tb_reg_scoreboard;
  localparam logic [3:0] N = 4'hF;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  reg_scoreboard_if sbi ();

  reg_scoreboard dut (
    .clock  (clock),
    .reset_n(reset_n),
    .sb     (sbi)
  );

  typedef struct {
    logic        dv;
    logic [3:0]  sa, sb, de, dm;
    logic        wv;
    logic [3:0]  we, wm;
    logic        sv;
    logic [3:0]  se, sm;
    logic        iss, stl;
    logic [14:0] busy;
    logic        err;
  } vec_t;

  vec_t vecs [30];

  function automatic vec_t mk(logic dv, logic [3:0] sa, logic [3:0] sb, logic [3:0] de, logic [3:0] dm,
                              logic wv, logic [3:0] we, logic [3:0] wm,
                              logic sv, logic [3:0] se, logic [3:0] sm,
                              logic iss, logic stl, logic [14:0] busy, logic err);
    vec_t v;
    v.dv = dv; v.sa = sa; v.sb = sb; v.de = de; v.dm = dm;
    v.wv = wv; v.we = we; v.wm = wm;
    v.sv = sv; v.se = se; v.sm = sm;
    v.iss = iss; v.stl = stl; v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    sbi.d_valid = 1'b0; sbi.d_srcA = N; sbi.d_srcB = N; sbi.d_dstE = N; sbi.d_dstM = N;
    sbi.w_valid = 1'b0; sbi.w_dstE = N; sbi.w_dstM = N;
    sbi.s_valid = 1'b0; sbi.s_dstE = N; sbi.s_dstM = N;
  endtask

  task automatic drive_vec(vec_t v);
    sbi.d_valid = v.dv; sbi.d_srcA = v.sa; sbi.d_srcB = v.sb; sbi.d_dstE = v.de; sbi.d_dstM = v.dm;
    sbi.w_valid = v.wv; sbi.w_dstE = v.we; sbi.w_dstM = v.wm;
    sbi.s_valid = v.sv; sbi.s_dstE = v.se; sbi.s_dstM = v.sm;
  endtask

  initial begin
    int pulses;

    // busy/err columns are the values visible before the vector's clock edge
    vecs[0]  = mk(0, N, N, N, N, 0, N, N, 0, N, N, 0, 0, 15'h0000, 0);
    vecs[1]  = mk(1, N, N, 3, N, 0, N, N, 0, N, N, 1, 0, 15'h0000, 0);
    vecs[2]  = mk(1, 3, N, 2, N, 0, N, N, 0, N, N, 0, 1, 15'h0008, 0);
    vecs[3]  = mk(1, 3, N, 2, N, 1, 3, N, 0, N, N, 0, 1, 15'h0008, 0);
    vecs[4]  = mk(1, 3, N, 2, N, 0, N, N, 0, N, N, 1, 0, 15'h0000, 0);
    vecs[5]  = mk(0, N, N, N, N, 1, 2, N, 0, N, N, 0, 0, 15'h0004, 0);
    vecs[6]  = mk(1, 4, 4, 4, 4, 0, N, N, 0, N, N, 1, 0, 15'h0000, 0);
    vecs[7]  = mk(0, N, N, N, N, 1, 4, N, 0, N, N, 0, 0, 15'h0010, 0);
    vecs[8]  = mk(0, N, N, N, N, 1, 4, N, 0, N, N, 0, 0, 15'h0010, 0);
    vecs[9]  = mk(0, N, N, N, N, 0, N, N, 0, N, N, 0, 0, 15'h0000, 0);
    vecs[10] = mk(1, N, N, 2, N, 0, N, N, 0, N, N, 1, 0, 15'h0000, 0);
    vecs[11] = mk(1, N, N, 2, N, 1, 2, N, 0, N, N, 1, 0, 15'h0004, 0);
    vecs[12] = mk(0, N, N, N, N, 0, N, N, 0, N, N, 0, 0, 15'h0004, 0);
    vecs[13] = mk(0, N, N, N, N, 1, 2, N, 0, N, N, 0, 0, 15'h0004, 0);
    vecs[14] = mk(0, N, N, N, N, 0, N, N, 0, N, N, 0, 0, 15'h0000, 0);
    vecs[15] = mk(1, N, N, 1, N, 0, N, N, 0, N, N, 1, 0, 15'h0000, 0);
    vecs[16] = mk(1, N, N, 1, N, 0, N, N, 0, N, N, 1, 0, 15'h0002, 0);
    vecs[17] = mk(1, N, N, 1, N, 0, N, N, 0, N, N, 1, 0, 15'h0002, 0);
    vecs[18] = mk(1, N, N, 1, N, 0, N, N, 0, N, N, 0, 1, 15'h0002, 0);
    vecs[19] = mk(0, N, N, N, N, 0, N, N, 0, N, N, 0, 0, 15'h0002, 0);
    vecs[20] = mk(0, N, N, N, N, 1, 1, N, 0, N, N, 0, 0, 15'h0002, 0);
    vecs[21] = mk(0, N, N, N, N, 0, N, N, 1, 1, N, 0, 0, 15'h0002, 0);
    vecs[22] = mk(0, N, N, N, N, 1, 1, N, 0, N, N, 0, 0, 15'h0002, 0);
    vecs[23] = mk(0, N, N, N, N, 1, 7, N, 0, N, N, 0, 0, 15'h0000, 0);
    vecs[24] = mk(0, N, N, N, N, 0, N, N, 0, N, N, 0, 0, 15'h0000, 1);
    vecs[25] = mk(1, N, N, 8, N, 0, N, N, 0, N, N, 1, 0, 15'h0000, 1);
    vecs[26] = mk(1, N, N, 8, N, 0, N, N, 0, N, N, 1, 0, 15'h0100, 1);
    vecs[27] = mk(1, N, N, 8, 8, 0, N, N, 0, N, N, 0, 1, 15'h0100, 1);
    vecs[28] = mk(0, N, N, N, N, 1, 8, 8, 0, N, N, 0, 0, 15'h0100, 1);
    vecs[29] = mk(0, N, N, N, N, 0, N, N, 0, N, N, 0, 0, 15'h0000, 1);

    drive_idle();
    sbi.drain_req = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      drive_vec(vecs[i]);
      #1;
      chk($sformatf("v%0d issue", i),   32'(sbi.issue),     32'(vecs[i].iss));
      chk($sformatf("v%0d stall_d", i), 32'(sbi.stall_d),   32'(vecs[i].stl));
      chk($sformatf("v%0d busy", i),    32'(sbi.busy_mask), 32'(vecs[i].busy));
      chk($sformatf("v%0d err", i),     32'(sbi.err),       32'(vecs[i].err));
      @(negedge clock);
    end

    // drain with two writes in flight
    drive_idle();
    sbi.d_valid = 1'b1; sbi.d_dstE = 4'd5;
    #1 chk("drain issue r5", 32'(sbi.issue), 32'd1);
    @(negedge clock);
    sbi.d_dstE = 4'd6;
    #1 chk("drain issue r6", 32'(sbi.issue), 32'd1);
    @(negedge clock);
    drive_idle();
    sbi.drain_req = 1'b1;
    #1 chk("drain_done in RUN", 32'(sbi.drain_done), 32'd0);
    @(negedge clock);
    sbi.d_valid = 1'b1; sbi.d_dstE = 4'd0;
    sbi.w_valid = 1'b1; sbi.w_dstE = 4'd5;
    #1;
    chk("drain stall_d", 32'(sbi.stall_d), 32'd1);
    chk("drain issue blocked", 32'(sbi.issue), 32'd0);
    chk("drain busy", 32'(sbi.busy_mask), 32'h0060);
    chk("drain_done early", 32'(sbi.drain_done), 32'd0);
    @(negedge clock);
    sbi.d_valid = 1'b0; sbi.d_dstE = N;
    sbi.w_dstE = 4'd6;
    #1 chk("drain_done before last retire", 32'(sbi.drain_done), 32'd0);
    @(negedge clock);
    drive_idle();
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      #1 if (sbi.drain_done === 1'b1) pulses++;
      @(negedge clock);
    end
    chk("drain_done pulse count", 32'(pulses), 32'd1);
    sbi.d_valid = 1'b1; sbi.d_dstE = 4'd0;
    sbi.drain_req = 1'b0;
    #1 chk("DONE stall_d", 32'(sbi.stall_d), 32'd1);
    @(negedge clock);
    #1 chk("back to RUN issue", 32'(sbi.issue), 32'd1);
    @(negedge clock);
    drive_idle();
    #1;
    chk("pre-reset busy", 32'(sbi.busy_mask), 32'h0001);
    chk("pre-reset err", 32'(sbi.err), 32'd1);

    // asynchronous reset mid-cycle, checked before any clock edge
    @(negedge clock);
    sbi.d_valid = 1'b1; sbi.d_dstE = 4'd9;
    #2 reset_n = 1'b0;
    #1;
    chk("reset busy", 32'(sbi.busy_mask), 32'h0000);
    chk("reset err", 32'(sbi.err), 32'd0);
    chk("reset issue", 32'(sbi.issue), 32'd0);
    chk("reset stall_d", 32'(sbi.stall_d), 32'd1);
    chk("reset drain_done", 32'(sbi.drain_done), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 chk("post-reset issue", 32'(sbi.issue), 32'd1);
    @(negedge clock);
    drive_idle();
    #1 chk("post-reset busy r9", 32'(sbi.busy_mask), 32'h0200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
